pix_line_fifo: RTL and testbench

Parametrised successor to the pixel-clock capture buffer. Captures image-sensor pixels while frame and line are valid. Tags each pixel with start-of-frame (SOF) and end-of-line (EOL) markers and stores them in a power-of-two-deep circular FIFO. The consumer drains it through a valid/ready handshake. Sits between the sensor pins and the downstream pixel pipeline, all in the pix_clk domain.

---
 rtl/pix_line_fifo_pkg.sv | 5 +
 rtl/pix_line_fifo_mem.sv | 18 +
 rtl/pix_line_fifo.sv | 99 +++++++++
 tb/tb_pix_line_fifo.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pix_line_fifo_pkg.sv
// pix_line_fifo_pkg: shared state encoding and entry tag layout for the pixel line FIFO
package pix_line_fifo_pkg;
  typedef enum logic [1:0] {SYNC, IDLE, FRAME} state_e;
  localparam int TagWidth = 2;
endpackage

// File: rtl/pix_line_fifo_mem.sv
// pix_line_fifo_mem: Depth x EntryWidth storage, registered write, asynchronous read
module pix_line_fifo_mem #(
  parameter int Depth = 8,
  parameter int EntryWidth = 14,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AddrWidth-1:0]  wr_addr,
  input  logic [EntryWidth-1:0] wr_data,
  input  logic [AddrWidth-1:0]  rd_addr,
  output logic [EntryWidth-1:0] rd_data
);
  logic [EntryWidth-1:0] mem_q [Depth];
  // write port; storage holds no reset since count gates visibility
  always_ff @(posedge clk) if (wr_en) mem_q[wr_addr] <= wr_data;
  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/pix_line_fifo.sv
// pix_line_fifo: sensor pixel capture with SOF/EOL tagging into a show-ahead circular FIFO
module pix_line_fifo import pix_line_fifo_pkg::*; #(
  parameter int PixWidth = 12,
  parameter int Depth = 8,
  parameter int CountWidth = $clog2(Depth + 1)
) (
  input  logic                  pix_clk,
  input  logic                  pix_rst,
  input  logic                  pix_frameValid,
  input  logic                  pix_lineValid,
  input  logic [PixWidth-1:0]   pix_d,
  output logic [PixWidth-1:0]   q,
  output logic                  qSOF,
  output logic                  qEOL,
  output logic                  qValid,
  input  logic                  qReady,
  output logic [CountWidth-1:0] count,
  output logic                  overflow,
  input  logic                  clearOverflow
);
  localparam int AddrWidth = $clog2(Depth);
  localparam int EntryWidth = PixWidth + TagWidth;
  state_e state_q, state_d;
  logic hold_valid_q, hold_valid_d, hold_sof_q, hold_sof_d, sof_pending_q, sof_pending_d;
  logic overflow_q, overflow_d;
  logic [PixWidth-1:0] hold_pix_q, hold_pix_d;
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic capture, push, pop, full, wr_en;
  logic [EntryWidth-1:0] wr_data, rd_data;
  pix_line_fifo_mem #(.Depth(Depth), .EntryWidth(EntryWidth), .AddrWidth(AddrWidth)) u_mem (
    .clk(pix_clk),
    .wr_en(wr_en),
    .wr_addr(wr_ptr_q),
    .wr_data(wr_data),
    .rd_addr(rd_ptr_q),
    .rd_data(rd_data)
  );
  // frame tracking: SYNC waits out any partial frame, pixels are only taken in FRAME
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      SYNC: if (!pix_frameValid) state_d = IDLE;
      IDLE: if (pix_frameValid) state_d = FRAME;
      FRAME: begin
        capture = pix_frameValid && pix_lineValid;
        if (!pix_frameValid) state_d = IDLE;
      end
      default: state_d = SYNC;
    endcase
  end
  // hold stage decides EOL by whether the next edge brings another pixel; FIFO bookkeeping
  always_comb begin
    push = hold_valid_q && (capture || !pix_lineValid || !pix_frameValid);
    pop = (count_q != '0) && qReady;
    full = count_q == CountWidth'(Depth);
    wr_en = push && (!full || pop);
    wr_data = {hold_pix_q, hold_sof_q, !capture};
    hold_valid_d = capture || (hold_valid_q && !push);
    hold_pix_d = capture ? pix_d : hold_pix_q;
    hold_sof_d = capture ? sof_pending_q : hold_sof_q;
    sof_pending_d = capture ? 1'b0 : (state_q == IDLE) ? 1'b1 : sof_pending_q;
    wr_ptr_d = wr_en ? wr_ptr_q + AddrWidth'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AddrWidth'(1) : rd_ptr_q;
    count_d = count_q + CountWidth'(wr_en) - CountWidth'(pop);
    overflow_d = (push && full && !pop) || (overflow_q && !clearOverflow);
    qValid = count_q != '0;
    q = qValid ? rd_data[EntryWidth-1:TagWidth] : '0;
    qSOF = qValid && rd_data[1];
    qEOL = qValid && rd_data[0];
    count = count_q;
    overflow = overflow_q;
  end
  // state registers with synchronous reset back to SYNC and an empty FIFO
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      state_q <= SYNC;
      hold_valid_q <= 1'b0;
      hold_sof_q <= 1'b0;
      hold_pix_q <= '0;
      sof_pending_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_sof_q <= hold_sof_d;
      hold_pix_q <= hold_pix_d;
      sof_pending_q <= sof_pending_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_pix_line_fifo.sv
// tb_pix_line_fifo: directed stimulus with a scoreboard queue checked by a pop monitor
module tb_pix_line_fifo;
  logic clk = 1'b0, rst = 1'b1, fv = 1'b0, lv = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic [11:0] d = '0, q;
  logic q_sof, q_eol, q_valid, ovf;
  logic [3:0] cnt;
  logic [13:0] exp_q[$];
  int pass_cnt = 0, total_cnt = 0;

  pix_line_fifo dut (
    .pix_clk(clk), .pix_rst(rst), .pix_frameValid(fv), .pix_lineValid(lv), .pix_d(d),
    .q(q), .qSOF(q_sof), .qEOL(q_eol), .qValid(q_valid), .qReady(rdy),
    .count(cnt), .overflow(ovf), .clearOverflow(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic push_exp(input int px, input logic s, input logic e);
    exp_q.push_back({12'(px), s, e});
  endtask

  task automatic cyc(input logic f, input logic l, input int px);
    fv = f;
    lv = l;
    d = 12'(px);
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int first, input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, first + i);
    cyc(1, 0, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && q_valid && rdy) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL beat: got unexpected %0h, expected none", {q, q_sof, q_eol});
      end else chk("beat", int'({q, q_sof, q_eol}), int'(exp_q.pop_front()));
    end
  end

  initial begin
    int t;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b0;
    chk("rst_count", int'(cnt), 0);
    chk("rst_valid", int'(q_valid), 0);
    chk("rst_head", int'({q, q_sof, q_eol}), 0);
    chk("rst_ovf", int'(ovf), 0);
    // basic line
    rdy = 1'b1;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    push_exp('h001, 1, 0); push_exp('h002, 0, 0); push_exp('h003, 0, 0); push_exp('h004, 0, 1);
    cyc(1, 1, 'h001);
    chk("lat_capture_edge", int'(q_valid), 0);
    cyc(1, 1, 'h002);
    chk("lat_next_edge", int'(q_valid), 1);
    cyc(1, 1, 'h003);
    cyc(1, 1, 'h004);
    repeat (4) cyc(1, 0, 0);
    // two lines, one frame
    push_exp('h010, 0, 0); push_exp('h011, 0, 0); push_exp('h012, 0, 1);
    push_exp('h020, 0, 0); push_exp('h021, 0, 0); push_exp('h022, 0, 1);
    line('h010, 3);
    repeat (2) cyc(1, 0, 0);
    line('h020, 3);
    repeat (4) cyc(1, 0, 0);
    chk("two_lines_drained", int'(cnt), 0);
    // overflow
    rdy = 1'b0;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    push_exp('h101, 1, 0);
    for (int i = 2; i <= 8; i++) push_exp('h100 + i, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 1, 'h100 + i);
      if (i == 9) begin
        chk("full_count", int'(cnt), 8);
        chk("full_no_ovf", int'(ovf), 0);
      end
      if (i == 10) chk("ovf_set", int'(ovf), 1);
    end
    chk("sat_count", int'(cnt), 8);
    clr = 1'b1;
    cyc(1, 0, 0);
    chk("ovf_set_wins", int'(ovf), 1);
    cyc(1, 0, 0);
    clr = 1'b0;
    chk("ovf_cleared", int'(ovf), 0);
    chk("count_after_drop", int'(cnt), 8);
    // full with simultaneous pop
    for (int i = 1; i <= 5; i++) push_exp('h200 + i, 0, 0);
    push_exp('h206, 0, 1);
    cyc(1, 1, 'h201);
    for (int i = 2; i <= 6; i++) begin
      rdy = 1'b1;
      cyc(1, 1, 'h200 + i);
      chk("fullpop_count", int'(cnt), 8);
      chk("fullpop_ovf", int'(ovf), 0);
    end
    cyc(1, 0, 0);
    chk("fullpop_eol_count", int'(cnt), 8);
    repeat (10) cyc(1, 0, 0);
    chk("fullpop_drained", int'(cnt), 0);
    cyc(0, 0, 0);
    // reset mid-frame
    rdy = 1'b0;
    cyc(1, 0, 0);
    cyc(1, 1, 'h301);
    cyc(1, 1, 'h302);
    rst = 1'b1;
    cyc(1, 1, 'h303);
    rst = 1'b0;
    chk("midrst_count", int'(cnt), 0);
    chk("midrst_valid", int'(q_valid), 0);
    chk("midrst_head", int'({q, q_sof, q_eol}), 0);
    rdy = 1'b1;
    cyc(1, 1, 'h304);
    cyc(1, 1, 'h305);
    cyc(1, 0, 0);
    cyc(1, 1, 'h306);
    cyc(1, 0, 0);
    chk("sync_ignore_count", int'(cnt), 0);
    chk("sync_ignore_valid", int'(q_valid), 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    push_exp('h401, 1, 0); push_exp('h402, 0, 1);
    line('h401, 2);
    repeat (3) cyc(1, 0, 0);
    // frame valid falls with line valid high
    push_exp('h3fd, 0, 0); push_exp('h3fe, 0, 0); push_exp('h3ff, 0, 1);
    cyc(1, 1, 'h3fd);
    cyc(1, 1, 'h3fe);
    cyc(1, 1, 'h3ff);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    push_exp('h501, 1, 1);
    cyc(1, 1, 'h501);
    cyc(1, 0, 0);
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      cyc(1, 0, 0);
      t++;
    end
    chk("all_beats_seen", exp_q.size(), 0);
    cyc(1, 0, 0);
    chk("end_count", int'(cnt), 0);
    chk("end_ovf", int'(ovf), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
